// File: rtl/riscv_pipe_stage_reg.sv
// riscv_pipe_stage_reg: valid/ready pipeline-stage register bank (NUM_CH x WIDTH).
// Supports downstream stall and synchronous flush between RV32I core stages.
// Build option: define RISCV_PIPE_SKID_EN to add a one-entry skid buffer so that
// o_ready becomes a registered signal with no combinational path from i_ready.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipe_stage_reg #(
    parameter int unsigned      NUM_CH        = 7,
    parameter int unsigned      WIDTH         = `XLEN,
    parameter logic [WIDTH-1:0] REGISTER_INIT = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [NUM_CH*WIDTH-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    input  logic                    i_flush
);

    localparam int unsigned DW = NUM_CH * WIDTH;

    logic          in_xfer;
    logic          out_xfer;
    logic [DW-1:0] data_q, data_d;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;
    assign o_data   = data_q;

`ifdef RISCV_PIPE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] skid_q, skid_d;

    // Ready depends only on the state register, never on i_ready.
    assign o_valid = (state_q != ST_EMPTY);
    assign o_ready = (state_q != ST_SKID);

    // State, output beat and skid beat registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_EMPTY;
            data_q  <= {NUM_CH{REGISTER_INIT}};
            skid_q  <= {NUM_CH{REGISTER_INIT}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state logic: flush empties both entries but leaves data untouched.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_FULL;
                        data_d  = i_data;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        data_d = i_data;
                    end else if (in_xfer) begin
                        state_d = ST_SKID;
                        skid_d  = i_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        state_d = ST_FULL;
                        data_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

`else

    logic valid_q, valid_d;

    assign o_valid = valid_q;
    assign o_ready = ~valid_q | i_ready;

    // Output beat and valid registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= 1'b0;
            data_q  <= {NUM_CH{REGISTER_INIT}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: flush beats capture, data holds whenever nothing is captured.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// Testbench for riscv_pipe_stage_reg: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the stage.
// Works with and without RISCV_PIPE_SKID_EN defined.

module tb_riscv_pipe_stage_reg;

    localparam int unsigned NUM_CH = 7;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DW     = NUM_CH * WIDTH;
    localparam logic [WIDTH-1:0] INIT = 32'h0000_0013;

`ifdef RISCV_PIPE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk;
    logic          rstn;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          i_flush;

    int n_total = 0;
    int n_bad   = 0;
    int delivered = 0;

    // Model: beats held by the stage, oldest first, plus the value on o_data.
    logic [DW-1:0] q[$];
    logic [DW-1:0] shown;

    riscv_pipe_stage_reg #(
        .NUM_CH        (NUM_CH),
        .WIDTH         (WIDTH),
        .REGISTER_INIT (INIT)
    ) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .i_flush (i_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int unsigned v);
        logic [DW-1:0] b;
        for (int unsigned k = 0; k < NUM_CH; k++) b[k*WIDTH +: WIDTH] = WIDTH'(v + k);
        return b;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int unsigned k = 0; k < NUM_CH; k++) b[k*WIDTH +: WIDTH] = $urandom;
        return b;
    endfunction

    // Stage accepts while it has room; base stage also when its beat leaves now.
    function automatic logic model_ready(input logic r);
`ifdef RISCV_PIPE_SKID_EN
        return (q.size() < CAP);
`else
        return (q.size() < CAP) || r;
`endif
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f,
                       output logic acc);
        logic rdy;
        @(negedge clk);
        i_valid = v; i_data = d; i_ready = r; i_flush = f;
        #1;
        rdy = model_ready(r);
        check("o_valid", DW'(o_valid), DW'(q.size() > 0));
        check("o_ready", DW'(o_ready), DW'(rdy));
        check("o_data", o_data, shown);
        if (o_valid && r) delivered++;
        acc = v & rdy & ~f;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (v && rdy) q.push_back(d);
        end
        if (q.size() > 0) shown = q[0];
    endtask

    task automatic idle(input int unsigned n, input logic r);
        logic acc;
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, rand_beat(), r, 1'b0, acc);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b0; i_ready = $urandom_range(0, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_o_valid", DW'(o_valid), DW'(0));
        check("rst_o_ready", DW'(o_ready), DW'(1));
        check("rst_o_data", o_data, {NUM_CH{INIT}});
        q.delete();
        shown = {NUM_CH{INIT}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Push n beats (channel0 = base+i) with i_ready low during [stall_at, stall_at+stall_len).
    task automatic stream(input int unsigned n, input int unsigned base,
                          input int unsigned stall_at, input int unsigned stall_len, input string tag);
        int unsigned sent = 0;
        int unsigned c = 0;
        logic acc;
        logic r;
        delivered = 0;
        while ((sent < n || q.size() > 0) && c < 200) begin
            r = !(c >= stall_at && c < stall_at + stall_len);
            cyc(sent < n, beat(base + sent), r, 1'b0, acc);
            if (acc) sent++;
            c++;
        end
        if (c >= 200) check({tag, "_timeout"}, DW'(c), DW'(0));
        check({tag, "_count"}, DW'(delivered), DW'(n));
    endtask

    initial begin
        logic acc;
        rstn = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1; i_flush = 1'b0;
        shown = {NUM_CH{INIT}};
        #12;
        do_reset();

        // Single beat, 0x100+k on channel k.
        cyc(1'b1, beat(32'h100), 1'b1, 1'b0, acc);
        check("single_acc", DW'(acc), DW'(1));
        idle(3, 1'b1);

        // Sixteen back-to-back beats, no stall.
        stream(16, 1, 1000, 0, "stream");
        idle(2, 1'b1);

        // A,B,C with a four-cycle stall once A is visible.
        stream(3, 32'hA0, 1, 4, "stall");
        idle(2, 1'b1);

        // Flush with a live beat while 0xDEAD is offered.
        cyc(1'b1, beat(32'h77), 1'b0, 1'b0, acc);
        cyc(1'b1, beat(32'hDEAD), 1'b0, 1'b1, acc);
        check("flush_drop", DW'(acc), DW'(0));
        idle(2, 1'b1);
        check("flush_keep", o_data, beat(32'h77));

`ifdef RISCV_PIPE_SKID_EN
        // Fill output and skid, flush, then a single fresh beat.
        cyc(1'b1, beat(32'h11), 1'b0, 1'b0, acc);
        cyc(1'b1, beat(32'h22), 1'b0, 1'b0, acc);
        cyc(1'b0, beat(32'h33), 1'b0, 1'b1, acc);
        cyc(1'b0, beat(32'h33), 1'b0, 1'b0, acc);
        check("drain_ready", DW'(o_ready), DW'(1));
        delivered = 0;
        cyc(1'b1, beat(32'h55), 1'b1, 1'b0, acc);
        idle(3, 1'b1);
        check("drain_once", DW'(delivered), DW'(1));
`endif

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7, rand_beat(), $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0, acc);
        end

        // Reset in the middle of traffic, then confirm nothing emerges.
        cyc(1'b1, rand_beat(), 1'b0, 1'b0, acc);
        do_reset();
        idle(3, 1'b1);
        for (int i = 0; i < 100; i++) begin
            cyc($urandom_range(0, 1), rand_beat(), $urandom_range(0, 1), 1'b0, acc);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
